// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int WAIT_CNT_W      = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// master = arbiter view, slave = core/memory view.
interface mem_arbiter_if;

    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRdata;
    logic        ifAck;

    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] dRdata;
    logic        dAck;

    logic        err;

    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memReady;

    modport master (
        input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memRdata, memReady,
        output ifRdata, ifAck, dRdata, dAck, err, memReq, memWe, memAddr, memWdata
    );

    modport slave (
        output ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memRdata, memReady,
        input  ifRdata, ifAck, dRdata, dAck, err, memReq, memWe, memAddr, memWdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one variable-latency memory,
// with a watchdog that forces completion. `define MEM_ARB_RR_EN for round-robin ties.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);

    state_t                  state_q, state_d;
    owner_t                  owner_q, owner_d;
    owner_t                  last_owner_q, last_owner_d;
    owner_t                  grant;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic [31:0]             if_rdata_q, if_rdata_d;
    logic [31:0]             d_rdata_q, d_rdata_d;
    logic [31:0]             rdata_sel;
    logic                    if_ack_q, if_ack_d;
    logic                    d_ack_q, d_ack_d;
    logic                    err_q, err_d;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wait_cnt_d   = wait_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;
        grant        = OWN_D;
        rdata_sel    = 32'h0000_0000;

        case (state_q)
            IDLE: begin
                if (bus.ifReq && bus.dReq) begin
`ifdef MEM_ARB_RR_EN
                    grant = (last_owner_q == OWN_D) ? OWN_IF : OWN_D;
`else
                    grant = OWN_D;
`endif
                end else if (bus.dReq) begin
                    grant = OWN_D;
                end else begin
                    grant = OWN_IF;
                end

                if (bus.ifReq || bus.dReq) begin
                    state_d    = WAIT;
                    owner_d    = grant;
                    mem_req_d  = 1'b1;
                    wait_cnt_d = '0;
                    if (grant == OWN_D) begin
                        mem_addr_d  = bus.dAddr;
                        mem_we_d    = bus.dWe;
                        mem_wdata_d = bus.dWdata;
                    end else begin
                        mem_addr_d  = bus.ifAddr;
                        mem_we_d    = 1'b0;
                    end
                end
            end

            WAIT: begin
                // memReady wins over a timeout landing on the same cycle
                if (bus.memReady || (wait_cnt_q == TIMEOUT_CNT)) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    rdata_sel = bus.memReady ? bus.memRdata : 32'h0000_0000;
                    err_d     = ~bus.memReady;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = rdata_sel;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = rdata_sel;
                        if_ack_d   = 1'b1;
                    end
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d      = IDLE;
                last_owner_d = owner_q;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            wait_cnt_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            if_rdata_q   <= 32'h0000_0000;
            d_rdata_q    <= 32'h0000_0000;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            err_q        <= err_d;
        end
    end

    assign bus.memReq   = mem_req_q;
    assign bus.memWe    = mem_we_q;
    assign bus.memAddr  = mem_addr_q;
    assign bus.memWdata = mem_wdata_q;
    assign bus.ifRdata  = if_rdata_q;
    assign bus.dRdata   = d_rdata_q;
    assign bus.ifAck    = if_ack_q;
    assign bus.dAck     = d_ack_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default build, TIMEOUT = 4).
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_arbiter_if bus();

    mem_arbiter #(
        .TIMEOUT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++; if (bus.memReq !== 1'b0) begin bad++; $display("[TB] FAIL rst_memReq got=%0h exp=0", bus.memReq); end
        total++; if (bus.memWe !== 1'b0) begin bad++; $display("[TB] FAIL rst_memWe got=%0h exp=0", bus.memWe); end
        total++; if (bus.memAddr !== 32'h0) begin bad++; $display("[TB] FAIL rst_memAddr got=%0h exp=0", bus.memAddr); end
        total++; if ({bus.ifAck, bus.dAck, bus.err} !== 3'b000) begin bad++; $display("[TB] FAIL rst_acks got=%0b exp=000", {bus.ifAck, bus.dAck, bus.err}); end
        total++; if ({bus.ifRdata, bus.dRdata} !== 64'h0) begin bad++; $display("[TB] FAIL rst_rdata got=%0h exp=0", {bus.ifRdata, bus.dRdata}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        bus.ifReq = 1'b1;
        bus.ifAddr = 32'h0000_0010;
        step();
        total++; if (bus.memReq !== 1'b1) begin bad++; $display("[TB] FAIL fetch_memReq got=%0h exp=1", bus.memReq); end
        total++; if (bus.memAddr !== 32'h10) begin bad++; $display("[TB] FAIL fetch_memAddr got=%0h exp=10", bus.memAddr); end
        total++; if (bus.memWe !== 1'b0) begin bad++; $display("[TB] FAIL fetch_memWe got=%0h exp=0", bus.memWe); end
        step();
        total++; if ({bus.memReq, bus.ifAck} !== 2'b10) begin bad++; $display("[TB] FAIL fetch_wait got=%0b exp=10", {bus.memReq, bus.ifAck}); end
        bus.memReady = 1'b1;
        bus.memRdata = 32'h0050_0093;
        step();
        bus.memReady = 1'b0;
        total++; if ({bus.ifAck, bus.dAck, bus.err} !== 3'b100) begin bad++; $display("[TB] FAIL fetch_ack got=%0b exp=100", {bus.ifAck, bus.dAck, bus.err}); end
        total++; if (bus.ifRdata !== 32'h0050_0093) begin bad++; $display("[TB] FAIL fetch_rdata got=%0h exp=00500093", bus.ifRdata); end
        total++; if (bus.memReq !== 1'b0) begin bad++; $display("[TB] FAIL fetch_memReq_drop got=%0h exp=0", bus.memReq); end
        step();
        total++; if ({bus.ifAck, bus.memReq} !== 2'b00) begin bad++; $display("[TB] FAIL fetch_no_regrant got=%0b exp=00", {bus.ifAck, bus.memReq}); end
        bus.ifReq = 1'b0;
        step();
    endtask

    task automatic test_store();
        bus.dReq = 1'b1;
        bus.dWe = 1'b1;
        bus.dAddr = 32'h0000_0100;
        bus.dWdata = 32'hDEAD_BEEF;
        step();
        total++; if ({bus.memReq, bus.memWe} !== 2'b11) begin bad++; $display("[TB] FAIL store_req_we got=%0b exp=11", {bus.memReq, bus.memWe}); end
        total++; if (bus.memAddr !== 32'h100) begin bad++; $display("[TB] FAIL store_memAddr got=%0h exp=100", bus.memAddr); end
        total++; if (bus.memWdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL store_memWdata got=%0h exp=deadbeef", bus.memWdata); end
        step();
        total++; if ({bus.memReq, bus.memWe, bus.dAck} !== 3'b110) begin bad++; $display("[TB] FAIL store_hold got=%0b exp=110", {bus.memReq, bus.memWe, bus.dAck}); end
        total++; if (bus.memWdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL store_wdata_hold got=%0h exp=deadbeef", bus.memWdata); end
        bus.memReady = 1'b1;
        bus.memRdata = 32'h1234_5678;
        step();
        bus.memReady = 1'b0;
        total++; if ({bus.dAck, bus.ifAck, bus.err, bus.memReq} !== 4'b1000) begin bad++; $display("[TB] FAIL store_ack got=%0b exp=1000", {bus.dAck, bus.ifAck, bus.err, bus.memReq}); end
        total++; if (bus.ifRdata !== 32'h0050_0093) begin bad++; $display("[TB] FAIL store_ifRdata_hold got=%0h exp=00500093", bus.ifRdata); end
        bus.dReq = 1'b0;
        bus.dWe = 1'b0;
        step();
        total++; if (bus.dAck !== 1'b0) begin bad++; $display("[TB] FAIL store_ack_pulse got=%0h exp=0", bus.dAck); end
    endtask

    task automatic test_tie(input logic [31:0] drd, input logic [31:0] ird);
        bus.ifReq = 1'b1;
        bus.ifAddr = 32'h0000_0004;
        bus.dReq = 1'b1;
        bus.dWe = 1'b0;
        bus.dAddr = 32'h0000_0200;
        step();
        total++; if (bus.memAddr !== 32'h200) begin bad++; $display("[TB] FAIL tie_data_first got=%0h exp=200", bus.memAddr); end
        bus.memReady = 1'b1;
        bus.memRdata = drd;
        step();
        bus.memReady = 1'b0;
        total++; if ({bus.dAck, bus.ifAck} !== 2'b10) begin bad++; $display("[TB] FAIL tie_dack got=%0b exp=10", {bus.dAck, bus.ifAck}); end
        total++; if (bus.dRdata !== drd) begin bad++; $display("[TB] FAIL tie_drdata got=%0h exp=%0h", bus.dRdata, drd); end
        bus.dReq = 1'b0;
        step();
        step();
        total++; if ({bus.memReq, bus.memWe, bus.memAddr} !== {2'b10, 32'h4}) begin bad++; $display("[TB] FAIL tie_fetch_second got=%0h exp=%0h", {bus.memReq, bus.memWe, bus.memAddr}, {2'b10, 32'h4}); end
        bus.memReady = 1'b1;
        bus.memRdata = ird;
        step();
        bus.memReady = 1'b0;
        total++; if ({bus.ifAck, bus.dAck} !== 2'b10) begin bad++; $display("[TB] FAIL tie_ifack got=%0b exp=10", {bus.ifAck, bus.dAck}); end
        total++; if (bus.ifRdata !== ird) begin bad++; $display("[TB] FAIL tie_ifrdata got=%0h exp=%0h", bus.ifRdata, ird); end
        bus.ifReq = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        bus.dReq = 1'b1;
        bus.dWe = 1'b0;
        bus.dAddr = 32'h0000_0300;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if ({bus.memReq, bus.dAck} !== 2'b10) begin bad++; $display("[TB] FAIL timeout_wait%0d got=%0b exp=10", i, {bus.memReq, bus.dAck}); end
        end
        step();
        total++; if ({bus.dAck, bus.err, bus.memReq} !== 3'b110) begin bad++; $display("[TB] FAIL timeout_ack_err got=%0b exp=110", {bus.dAck, bus.err, bus.memReq}); end
        total++; if (bus.dRdata !== 32'h0) begin bad++; $display("[TB] FAIL timeout_rdata got=%0h exp=0", bus.dRdata); end
        bus.dReq = 1'b0;
        step();
        total++; if (bus.err !== 1'b0) begin bad++; $display("[TB] FAIL timeout_err_pulse got=%0h exp=0", bus.err); end
        bus.ifReq = 1'b1;
        bus.ifAddr = 32'h0000_0020;
        step();
        bus.memReady = 1'b1;
        bus.memRdata = 32'hCCCC_0001;
        step();
        bus.memReady = 1'b0;
        total++; if ({bus.ifAck, bus.err} !== 2'b10) begin bad++; $display("[TB] FAIL after_timeout_ack got=%0b exp=10", {bus.ifAck, bus.err}); end
        total++; if (bus.ifRdata !== 32'hCCCC_0001) begin bad++; $display("[TB] FAIL after_timeout_rdata got=%0h exp=cccc0001", bus.ifRdata); end
        bus.ifReq = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_wait();
        bus.dReq = 1'b1;
        bus.dWe = 1'b1;
        bus.dAddr = 32'h0000_0400;
        bus.dWdata = 32'h5555_AAAA;
        step();
        total++; if (bus.memReq !== 1'b1) begin bad++; $display("[TB] FAIL midrst_enter got=%0h exp=1", bus.memReq); end
        reset = 1'b1;
        bus.dReq = 1'b0;
        bus.dWe = 1'b0;
        step();
        reset = 1'b0;
        total++; if ({bus.memReq, bus.memWe, bus.memAddr, bus.memWdata} !== 66'h0) begin bad++; $display("[TB] FAIL midrst_mem got=%0h exp=0", {bus.memReq, bus.memWe, bus.memAddr, bus.memWdata}); end
        total++; if ({bus.ifRdata, bus.dRdata, bus.ifAck, bus.dAck, bus.err} !== 67'h0) begin bad++; $display("[TB] FAIL midrst_resp got=%0h exp=0", {bus.ifRdata, bus.dRdata, bus.ifAck, bus.dAck, bus.err}); end
        bus.memReady = 1'b1;
        bus.memRdata = 32'hFFFF_FFFF;
        step();
        bus.memReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if ({bus.ifAck, bus.dAck, bus.memReq, bus.err} !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_late_ready%0d got=%0b exp=0000", i, {bus.ifAck, bus.dAck, bus.memReq, bus.err}); end
        end
        total++; if (bus.dRdata !== 32'h0) begin bad++; $display("[TB] FAIL midrst_drdata got=%0h exp=0", bus.dRdata); end
    endtask

    task automatic test_back_to_back();
        bus.memReady = 1'b1;
        bus.memRdata = 32'h0000_0077;
        bus.dReq = 1'b1;
        bus.dWe = 1'b0;
        bus.dAddr = 32'h0000_0500;
        bus.ifReq = 1'b1;
        bus.ifAddr = 32'h0000_0600;
        for (int k = 0; k < 12; k++) begin
            step();
            total++; if ({bus.dAck, bus.ifAck} !== {(k % 3 == 1), 1'b0}) begin bad++; $display("[TB] FAIL b2b_cycle%0d got=%0b exp=%0b", k, {bus.dAck, bus.ifAck}, {(k % 3 == 1), 1'b0}); end
            if (k % 3 == 0) begin
                total++; if (bus.memAddr !== 32'h500) begin bad++; $display("[TB] FAIL b2b_addr%0d got=%0h exp=500", k, bus.memAddr); end
            end
        end
        bus.dReq = 1'b0;
        step();
        total++; if ({bus.memReq, bus.memAddr} !== {1'b1, 32'h600}) begin bad++; $display("[TB] FAIL b2b_fetch_grant got=%0h exp=%0h", {bus.memReq, bus.memAddr}, {1'b1, 32'h600}); end
        step();
        total++; if ({bus.ifAck, bus.ifRdata} !== {1'b1, 32'h77}) begin bad++; $display("[TB] FAIL b2b_fetch_ack got=%0h exp=%0h", {bus.ifAck, bus.ifRdata}, {1'b1, 32'h77}); end
        bus.ifReq = 1'b0;
        bus.memReady = 1'b0;
        step();
        step();
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.ifReq = 1'b0;
        bus.ifAddr = 32'h0;
        bus.dReq = 1'b0;
        bus.dWe = 1'b0;
        bus.dAddr = 32'h0;
        bus.dWdata = 32'h0;
        bus.memRdata = 32'h0;
        bus.memReady = 1'b0;
        test_reset();
        test_fetch();
        test_store();
        test_tie(32'hAAAA_0001, 32'hBBBB_0001);
        test_tie(32'hAAAA_0002, 32'hBBBB_0002);
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
